imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory: receives a program as a byte stream (valid/ready),
//  packs bytes into 32-bit instruction words and writes them into a writable instruction RAM.
//  Sits between the host byte link (UART RX or bench) and the imem write port.
//  busy holds the CPU off the memory while loading.
// PARAMETERS
//  ADDR_W   8   imem word-address width; depth = 2**ADDR_W words
//  DATA_W   32  instruction width; fixed at 32, since 4 bytes make one word
// PORTS
//  clk        in   1         single clock; all logic on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  start      in   1         1-cycle pulse that begins a load; sampled only in IDLE
//  len        in   ADDR_W+1  number of words to load; legal range 1..2**ADDR_W
//  s_byte     in   8         incoming program byte
//  s_valid    in   1         s_byte is valid
//  s_ready    out  1         loader accepts a byte this cycle
//  we         out  1         imem write enable, 1-cycle pulse
//  wa         out  ADDR_W    imem write word address
//  wd         out  32        imem write data
//  busy       out  1         load in progress; the CPU is held while high
//  done       out  1         1-cycle pulse at the end of a load
//  err        out  1         1-cycle pulse on an illegal len or a checksum mismatch
// BEHAVIOUR
//  - Reset: state=IDLE; s_ready, we, busy, done and err are 0; wa=0; wd=0.
//    Any partial word and byte count are cleared.
//    Reset mid-load aborts the load; no write is issued for a partial word.
//  - Handshake: a byte transfers when s_valid && s_ready.
//    s_ready is a Moore output: 1 only in RECV (and CSUM).
//  - FSM states: IDLE, RECV, WRITE, CSUM, DONE.
//  - IDLE -> RECV: on start with 1 <= len <= 2**ADDR_W. Latch len; clear the address and byte counters.
//  - IDLE, illegal len: start with len==0 or len>2**ADDR_W pulses err in the next cycle.
//    The state stays IDLE and no write is issued.
//  - start outside IDLE is ignored; len is not re-latched.
//  - RECV: each accepted byte shifts in: word <= {word[23:0], s_byte}, so the first byte lands in [31:24].
//    On acceptance of the 4th byte -> WRITE.
//  - WRITE: for exactly one cycle, we=1, wa=addr, wd=word, s_ready=0.
//    Latency: the 4th byte is accepted at cycle N; we is high at cycle N+1.
//    Then addr increments. If this was the last word -> DONE (or CSUM with the macro); else -> RECV.
//  - DONE: done=1 for one cycle, then -> IDLE.
//    busy=1 in every state except IDLE, so it falls in the cycle after done.
//  - No address wrap: a maximum len of 2**ADDR_W ends at wa=2**ADDR_W-1.
//  - All outputs except s_ready and busy are registered.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//   - A 32-bit running sum (mod 2^32) of the written words is kept.
//   - After the last WRITE, the FSM enters CSUM and accepts 4 more bytes, MSB first.
//   - The received value is compared with the sum. On mismatch, err and done pulse in the same cycle.
//   - The words already written stay in memory.
//  Undefined: CSUM is unreachable; no sum logic; err flags only an illegal len.
// STRUCTURE
//  - imem_loader_pkg: state enum, BYTES_PER_WORD=4, NOP_WORD=32'h0000_0000.
//  - Sub-module byte_word_packer: shift register plus 2-bit byte counter.
//    Signals: load/clear inputs; word and word_full outputs.
//    Reused by the CSUM phase to assemble the checksum.
// TESTING
//  1. len=1; bytes 20,01,00,CA -> single we with wa=0, wd=32'h200100CA; done next cycle; busy then 0.
//  2. len=5; words 200100CA then 00210820 x4; random s_valid gaps.
//     -> 5 writes at wa=0..4, data in order; we never high on consecutive cycles.
//  3. start with len=0, then with len=257 -> err pulse each time; we, busy and done stay 0.
//  4. Reset asserted after 2 bytes of word 0 -> we stays 0; outputs at reset values.
//     A new load with len=1 writes wa=0.
//  5. start pulsed in RECV with a different len -> ignored; the original len is honoured
//     (exact write count checked).
//  6. Macro on; len=2; words 00000001, 00000002:
//     checksum 00000003 -> done with err=0; checksum 00000004 -> done with err=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_e        : loader FSM states (CSUM is reachable only with IMEM_LOADER_CHECKSUM_EN)
//   BYTES_PER_WORD : bytes packed into one instruction word
//   NOP_WORD       : value an emptied packer holds
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// byte_word_packer: shifts bytes MSB-first into a 32-bit word and flags
// the byte that completes it.
//   clk, rst_n : clock, async active-low reset
//   clear      : empty the word and restart the byte count (wins over load)
//   load       : byte_in is accepted this cycle
//   byte_in    : incoming byte
//   word       : word including the byte being loaded this cycle
//   word_full  : this load completes a word (4th byte)
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = 2'd0;
      word_d = NOP_WORD;
    end else if (load) begin
      word_d = {word_q[23:0], byte_in};
      cnt_d  = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  // Exposing the next value lets the loader register the full word in the
  // same cycle the 4th byte is accepted.
  assign word      = word_d;
  assign word_full = load && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= NOP_WORD;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a valid/ready byte stream, packs it
// into 32-bit words and writes them to the instruction RAM write port.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing 32-bit checksum).
//   clk, rst_n       : clock, async active-low reset
//   start, len       : begin a load of len words (1..2**ADDR_W), IDLE only
//   s_byte/s_valid/s_ready : byte stream handshake
//   we, wa, wd       : registered imem write port
//   busy             : load in progress (any state but IDLE)
//   done, err        : registered 1-cycle status pulses
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        s_byte,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         sum_q, sum_d;
`endif

  logic        accept, len_ok, last_word;
  logic        pk_clear, pk_full;
  logic [31:0] pk_word;

  assign s_ready   = (state_q == ST_RECV) || (state_q == ST_CSUM);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = s_valid && s_ready;
  assign len_ok    = (len != '0) && (len <= MAX_LEN);
  assign last_word = (({1'b0, addr_q} + 1'b1) == len_q);

  byte_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .load      (accept),
    .byte_in   (s_byte),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pk_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d  = ST_RECV;
            len_d    = len;
            addr_d   = '0;
            pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d    = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        // Registering the write here puts we high in the WRITE cycle.
        if (pk_full) begin
          we_d    = 1'b1;
          wa_d    = addr_q;
          wd_d    = DATA_W'(pk_word);
          state_d = ST_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + pk_word;
`endif
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + 1'b1;  // wraps only past the last word, never used
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (pk_full) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = (pk_word != sum_q);
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads; expected writes and status pulses
// go into a scoreboard queue that a negedge monitor drains.
// Build with IMEM_LOADER_CHECKSUM_EN to also exercise the checksum phase.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic [7:0]        s_byte = '0;
  logic              s_valid = 1'b0;
  logic              s_ready, we, busy, done, err;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .s_byte(s_byte), .s_valid(s_valid), .s_ready(s_ready),
    .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int          kind;  // 0 write, 1 done, 2 err alone
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        e;
  } ev_t;

  ev_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] prog [0:255];
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] a, input logic [31:0] d, input logic e);
    ev_t ev;
    ev.kind = kind; ev.wa = a; ev.wd = d; ev.e = e;
    sb.push_back(ev);
  endtask

  // Monitor: every write / done / err pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t ev;
    if (rst_n) begin
      if (we) begin
        chk("we_back_to_back", {63'd0, prev_we}, 64'd0);
        if (sb.size() == 0) chk("unexpected_we", 64'd1, 64'd0);
        else begin
          ev = sb.pop_front();
          chk("we_kind", 64'(ev.kind), 64'd0);
          chk("wa", 64'(wa), 64'(ev.wa));
          chk("wd", 64'(wd), 64'(ev.wd));
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          ev = sb.pop_front();
          chk("done_kind", 64'(ev.kind), 64'd1);
          chk("done_err", 64'(err), 64'(ev.e));
        end
      end else if (err) begin
        if (sb.size() == 0) chk("unexpected_err", 64'd1, 64'd0);
        else begin
          ev = sb.pop_front();
          chk("err_kind", 64'(ev.kind), 64'd2);
        end
      end
      prev_we = we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after gap idle cycles; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1; s_byte = b;
    t = 0;
    while (!s_ready && t < 50) begin tick(); t++; end
    if (!s_ready) chk("s_ready_timeout", 64'd1, 64'd0);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_we"},      64'(we),      64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_done"},    64'(done),    64'd0);
    chk({tag, "_err"},     64'(err),     64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_wa"},      64'(wa),      64'd0);
    chk({tag, "_wd"},      64'(wd),      64'd0);
  endtask

  // Full load of prog[0..n-1]; csum_delta corrupts the sent checksum.
  task automatic run_load(input int n, input int gapmax, input logic mid_start,
                          input logic [31:0] csum_delta);
    logic [31:0] sum, w;
    logic        exp_err;
    sum = '0;
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      push_ev(0, 8'(i), prog[i], 1'b0);
      sum = sum + prog[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = (csum_delta != 0);
`endif
    push_ev(1, 8'd0, 32'd0, exp_err);
    pulse_start((ADDR_W+1)'(n));
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) begin
        if (mid_start && i == 0 && b == 2) pulse_start((ADDR_W+1)'(n + 3));
        send_byte(w[31-8*b -: 8], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
      end
      if (i < 3 || i == n - 1) chk("we_latency", 64'(we), 64'd1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    w = sum + csum_delta;
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], 0);
    chk("done_after_csum", 64'(done), 64'd1);
`else
    tick();
    chk("done_after_write", 64'(done), 64'd1);
`endif
    tick();
    chk("busy_fall", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #1;
    check_idle_outputs("reset");
    #20 rst_n = 1'b1;
    tick();

    // 1: single word
    prog[0] = 32'h2001_00CA;
    run_load(1, 0, 1'b0, 32'd0);

    // 2: five words with valid gaps
    prog[0] = 32'h2001_00CA;
    for (int i = 1; i < 5; i++) prog[i] = 32'h0021_0820;
    run_load(5, 3, 1'b0, 32'd0);

    // 3: illegal lengths
    push_ev(2, 8'd0, 32'd0, 1'b0);
    pulse_start(9'd0);
    chk("err_len0", 64'(err), 64'd1);
    chk("busy_len0", 64'(busy), 64'd0);
    push_ev(2, 8'd0, 32'd0, 1'b0);
    pulse_start(9'd257);
    chk("err_len257", 64'(err), 64'd1);
    chk("busy_len257", 64'(busy), 64'd0);
    tick();
    chk("err_one_cycle", 64'(err), 64'd0);

    // 4: reset after two bytes of a word
    pulse_start(9'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    #2;
    check_idle_outputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    prog[0] = 32'hDEAD_BEEF;
    run_load(1, 0, 1'b0, 32'd0);

    // 5: start during RECV with another len is ignored
    prog[0] = 32'h0102_0304;
    prog[1] = 32'hA0B0_C0D0;
    run_load(2, 1, 1'b1, 32'd0);

    // maximum length, last address 255
    for (int i = 0; i < 256; i++) prog[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    run_load(256, 0, 1'b0, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum good then bad
    prog[0] = 32'h0000_0001;
    prog[1] = 32'h0000_0002;
    run_load(2, 0, 1'b0, 32'd0);
    run_load(2, 0, 1'b0, 32'd1);
`endif

    repeat (4) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
